mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 5-stage pipeline, between the EX stage and write-back. Holds the EX/MEM pipeline register, runs lw/sw through a variable-latency req/ack data-memory port, and stalls the upstream stages while an access is outstanding. Produces the MEM/WB register and the forwarding taps (`EXMEM_ALU_o`, `MEMWB_WriteData_o`) that the EX stage consumes.

## Interface
- `TIMEOUT`, default 16: maximum request cycles without ack before abort. Legal range 1..255.
- `clk_i`  in  1  clock, all state on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `RegWrite_i`, `MemtoReg_i`, `MemRead_i`, `MemWrite_i`  in  1 each  control signals from EX.
- `ALU_result_i`  in  32  address or ALU result.
- `rt_data_i`  in  32  store data, already forwarded.
- `dest_reg_i`  in  5  write-back register number.
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  32  word address.
- `dmem_wdata_o`  out  32  store data.
- `dmem_ack_i`  in  1  access complete; `dmem_rdata_i` is valid in the same cycle.
- `dmem_rdata_i`  in  32  load data.
- `stall_o`  out  1  freeze PC, IF/ID and ID/EX.
- `EXMEM_ALU_o`  out  32  registered ALU result, forwarding source.
- `EXMEM_RegWrite_o`  out  1  registered RegWrite, to the forwarding unit.
- `EXMEM_dest_reg_o`  out  5  registered destination, to the forwarding unit.
- `MEMWB_RegWrite_o`  out  1  MEM/WB RegWrite.
- `MEMWB_dest_reg_o`  out  5  MEM/WB destination.
- `MEMWB_WriteData_o`  out  32  selects loaded data when MEM/WB MemtoReg = 1, else the MEM/WB ALU result.
- `timeout_o`  out  1  sticky: an access was aborted.
- `misalign_o`  out  1  sticky: a misaligned access was seen. Tied to 0 unless `MEM_ALIGN_CHK_EN` is defined.

## Operation
- **EX/MEM register:** loads all `*_i` fields on every edge where `stall_o` = 0, and holds while `stall_o` = 1.
- A memory op is an EX/MEM entry with MemRead or MemWrite set. If both are set, the op is a write and no data is captured.
- **State machine, state IDLE:**
  - With a memory op present, `dmem_req_o` = 1.
  - If `dmem_ack_i` = 1 in the same cycle, the op completes and `stall_o` = 0.
  - Otherwise `stall_o` = 1 and the state moves to WAIT.
- **State machine, state WAIT:**
  - `dmem_req_o` = 1 and `stall_o` = 1 until ack arrives.
  - On the ack cycle: `stall_o` = 0, the op completes, and the state returns to IDLE.
- **Request fields:**
  - `dmem_we_o` = MemWrite.
  - `dmem_addr_o` = `{ALU[31:2], 2'b00}`.
  - `dmem_wdata_o` = EX/MEM rt_data.
  - These fields are stable while `dmem_req_o` = 1. This holds because EX/MEM is frozen during the request.
- **Completion:** `stall_o` falls in the completion cycle, so EX/MEM loads the next instruction at that edge. A completed op is never reissued.
- **Timeout:**
  - An 8-bit counter clears whenever `dmem_req_o` = 0 or ack arrives, and increments on each request cycle without ack.
  - A request cycle without ack while the counter equals `TIMEOUT`−1 aborts the op: `stall_o` = 0, the state returns to IDLE, and `timeout_o` is set.
  - For an aborted op, the MEM/WB entry has RegWrite forced to 0 and read data 0.
  - As a result, `dmem_req_o` is high for at most `TIMEOUT` consecutive cycles.
- **MEM/WB register:** loads every edge.
  - When `stall_o` = 1, it loads a bubble: RegWrite = 0, all other fields 0.
  - Otherwise it loads the EX/MEM fields, plus `dmem_rdata_i` when a read completes with ack.
- Non-memory ops pass through in one cycle with no stall.

## Timing
- Reset drives every register and every output to 0, and the state to IDLE. `dmem_req_o` drops as soon as reset asserts, including in the middle of a WAIT. After reset, the sticky flags clear only by reset.
- **Latency:** EX inputs appear on `EXMEM_*` one edge after capture. `MEMWB_*` follows one edge after completion.
- `stall_o` depends combinationally on `dmem_ack_i`. This is the only combinational input-to-output path.
- A zero-wait load adds no stall. An access acked N cycles after its first request cycle stalls for N cycles.

## Configuration
- `MEM_ALIGN_CHK_EN` defined:
  - A memory op with `ALU[1:0]` ≠ 0 issues no request and causes no stall.
  - `misalign_o` is set.
  - The MEM/WB entry has RegWrite forced to 0.
- `MEM_ALIGN_CHK_EN` undefined: address bits [1:0] are ignored, and `misalign_o` is constant 0.

## Structure
- Shared package holds:
  - the state encoding (IDLE, WAIT);
  - the EX/MEM and MEM/WB struct typedefs;
  - the data width (32) and register-address width (5) constants.
- One sub-module, `mem_req_fsm`: state, timeout counter, `dmem_req_o`, `stall_o`, completion and abort pulses. Pipeline registers stay in the top module.

## Test plan
- **Zero-wait load:** lw to 0x100 with ack in the request cycle and rdata 0xDEADBEEF, dest 5 → `stall_o` never high; next edge `MEMWB_WriteData_o` = 0xDEADBEEF, `MEMWB_dest_reg_o` = 5, `MEMWB_RegWrite_o` = 1.
- **Slow store:** sw to 0x200 with data 0x55, ack on the 3rd request cycle → `dmem_req_o` high for 3 cycles, `stall_o` high for 2 cycles, 2 bubbles in MEM/WB, exactly one write.
- **R-type passthrough:** add with ALU result 0x12, dest 3 → `EXMEM_ALU_o` = 0x12 one edge later; `MEMWB_WriteData_o` = 0x12 the edge after.
- **Timeout:** `TIMEOUT` = 4, lw, never acked → request high for exactly 4 cycles, then `timeout_o` = 1, `MEMWB_RegWrite_o` = 0, pipeline resumes.
- **Reset during WAIT:** reset 2 cycles into a pending access → `dmem_req_o` and `stall_o` go to 0 immediately; after release, the state is IDLE with all outputs 0.
- **Misaligned load:** with `MEM_ALIGN_CHK_EN` defined, lw to 0x1002 → no request, `misalign_o` = 1, `MEMWB_RegWrite_o` = 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM state encoding, pipeline register layouts, widths.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rt_data;
        logic [REG_W-1:0]  dest;
    } exmem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdata;
        logic [REG_W-1:0]  dest;
    } memwb_t;

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: IDLE/WAIT state, timeout counter, stall and
// completion/abort pulses. The request is held for as long as EX/MEM holds a memory op.
module mem_req_fsm
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic mem_op_i,
    input  logic ack_i,
    output logic req_o,
    output logic stall_o,
    output logic done_o,
    output logic abort_o
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    mem_state_e state;
    logic [7:0] cnt;

    assign req_o   = mem_op_i;
    assign done_o  = req_o & ack_i;
    assign abort_o = req_o & ~ack_i & (cnt == LAST);
    assign stall_o = req_o & ~ack_i & ~abort_o;

    // cnt counts elapsed un-acked request cycles; it is always 0 in IDLE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall_o) begin
                        state <= WAIT;
                        cnt   <= 8'd1;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT: begin
                    if (stall_o) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers around a req/ack data-memory port.
// Optional MEM_ALIGN_CHK_EN drops misaligned accesses and flags them on misalign_o.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [REG_W-1:0]  dest_reg_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] EXMEM_ALU_o,
    output logic              EXMEM_RegWrite_o,
    output logic [REG_W-1:0]  EXMEM_dest_reg_o,
    output logic              MEMWB_RegWrite_o,
    output logic [REG_W-1:0]  MEMWB_dest_reg_o,
    output logic [DATA_W-1:0] MEMWB_WriteData_o,
    output logic              timeout_o,
    output logic              misalign_o
);

    exmem_t exmem, exmem_d;
    memwb_t memwb, memwb_d;
    logic   mem_op, misal, stall, done, abort, is_read, timeout_q;

    assign exmem_d = '{reg_write: RegWrite_i, mem_to_reg: MemtoReg_i, mem_read: MemRead_i,
                       mem_write: MemWrite_i, alu: ALU_result_i, rt_data: rt_data_i,
                       dest: dest_reg_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)    exmem <= '0;
        else if (!stall) exmem <= exmem_d;
    end

    assign mem_op  = exmem.mem_read | exmem.mem_write;
    assign is_read = exmem.mem_read & ~exmem.mem_write;

`ifdef MEM_ALIGN_CHK_EN
    logic misalign_q;
    assign misal = mem_op & (exmem.alu[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)   misalign_q <= 1'b0;
        else if (misal) misalign_q <= 1'b1;
    end
    assign misalign_o = misalign_q;
`else
    assign misal      = 1'b0;
    assign misalign_o = 1'b0;
`endif

    mem_req_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .mem_op_i(mem_op & ~misal),
        .ack_i   (dmem_ack_i),
        .req_o   (dmem_req_o),
        .stall_o (stall),
        .done_o  (done),
        .abort_o (abort)
    );

    // A stalled cycle pushes a bubble; dropped ops (abort/misaligned) never write back.
    always_comb begin
        memwb_d = '0;
        if (!stall) begin
            memwb_d.reg_write  = exmem.reg_write & ~abort & ~misal;
            memwb_d.mem_to_reg = exmem.mem_to_reg;
            memwb_d.alu        = exmem.alu;
            memwb_d.dest       = exmem.dest;
            memwb_d.rdata      = (is_read & done) ? dmem_rdata_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            memwb     <= '0;
            timeout_q <= 1'b0;
        end else begin
            memwb <= memwb_d;
            if (abort) timeout_q <= 1'b1;
        end
    end

    assign stall_o           = stall;
    assign dmem_we_o         = exmem.mem_write;
    assign dmem_addr_o       = {exmem.alu[DATA_W-1:2], 2'b00};
    assign dmem_wdata_o      = exmem.rt_data;
    assign EXMEM_ALU_o       = exmem.alu;
    assign EXMEM_RegWrite_o  = exmem.reg_write;
    assign EXMEM_dest_reg_o  = exmem.dest;
    assign MEMWB_RegWrite_o  = memwb.reg_write;
    assign MEMWB_dest_reg_o  = memwb.dest;
    assign MEMWB_WriteData_o = memwb.mem_to_reg ? memwb.rdata : memwb.alu;
    assign timeout_o         = timeout_q;

endmodule
